// File: rtl/rot_pkg.sv
// Shared constants for the rotation coefficient path: widths, Q7.10 format
// and the sequencer state encoding.
package rot_pkg;

  localparam int COEF_W  = 17;
  localparam int ANG_W   = 3;
  localparam int FRAC    = 10;
  localparam int LUT_LAT = 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COS  = 2'd1;
  localparam logic [1:0] SIN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Wide enough to count up to the lookup latency; never narrower than one bit.
  function automatic int cntWidth(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/rot_coef_sequencer_if.sv
// Request, lookup and coefficient buses of the coefficient sequencer.
// The master modport is the sequencer side, slave is the environment side.
interface rot_coef_sequencer_if
  import rot_pkg::*;
#(
  parameter int AW = ANG_W,
  parameter int CW = COEF_W
);

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_aci;
  logic          req_eksi;

  logic [AW-1:0] lut_aci;
  logic          lut_eksi;
  logic          lut_mode;
  logic [CW-1:0] lut_out;

  logic          coef_valid;
  logic          coef_ready;
  logic [CW-1:0] cos_q;
  logic [CW-1:0] sin_q;

  modport master (
    input  req_valid, req_aci, req_eksi, lut_out, coef_ready,
    output req_ready, lut_aci, lut_eksi, lut_mode, coef_valid, cos_q, sin_q
  );

  modport slave (
    output req_valid, req_aci, req_eksi, lut_out, coef_ready,
    input  req_ready, lut_aci, lut_eksi, lut_mode, coef_valid, cos_q, sin_q
  );

endinterface

// File: rtl/rot_coef_cache.sv
// One-entry tag store remembering the last completed angle request,
// used by the sequencer to skip the lookup on a repeat request.
module rot_coef_cache
  import rot_pkg::*;
#(
  parameter int AW = ANG_W
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          storeEn_i,
  input  logic [AW-1:0] storeAci_i,
  input  logic          storeEksi_i,
  input  logic [AW-1:0] lookupAci_i,
  input  logic          lookupEksi_i,
  output logic          hit_o
);

  logic [AW-1:0] tagAci_q,  tagAci_d;
  logic          tagEksi_q, tagEksi_d;
  logic          hitVld_q,  hitVld_d;

  always_comb begin
    tagAci_d  = tagAci_q;
    tagEksi_d = tagEksi_q;
    hitVld_d  = hitVld_q;
    if (storeEn_i) begin
      tagAci_d  = storeAci_i;
      tagEksi_d = storeEksi_i;
      hitVld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tagAci_q  <= '0;
      tagEksi_q <= 1'b0;
      hitVld_q  <= 1'b0;
    end else begin
      tagAci_q  <= tagAci_d;
      tagEksi_q <= tagEksi_d;
      hitVld_q  <= hitVld_d;
    end
  end

  assign hit_o = hitVld_q && (tagAci_q == lookupAci_i) && (tagEksi_q == lookupEksi_i);

endmodule

// File: rtl/rot_coef_sequencer.sv
// Sequences the shared sin/cos lookup (cos phase, then sin phase) per angle request.
// Optional repeat-request bypass is enabled by defining ROT_COEF_CACHE_EN.
module rot_coef_sequencer
  import rot_pkg::*;
#(
  parameter int LAT = LUT_LAT
)(
  input  logic                 clk,
  input  logic                 reset,
  rot_coef_sequencer_if.master bus,
  output logic                 busy
);

  localparam int CNT_W = cntWidth(LAT);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [ANG_W-1:0]  lutAci_q,  lutAci_d;
  logic              lutEksi_q, lutEksi_d;
  logic              lutMode_q, lutMode_d;
  logic [COEF_W-1:0] cosCoef_q, cosCoef_d;
  logic [COEF_W-1:0] sinCoef_q, sinCoef_d;
  logic              lastPhase;

  // The lookup result is captured on the edge where the wait counter reaches the latency.
  assign lastPhase = (cnt_q == LAT_CNT);

`ifdef ROT_COEF_CACHE_EN
  logic cacheHit;

  rot_coef_cache #(.AW(ANG_W)) u_cache (
    .clk          (clk),
    .reset        (reset),
    .storeEn_i    ((state_q == SIN) && lastPhase),
    .storeAci_i   (lutAci_q),
    .storeEksi_i  (lutEksi_q),
    .lookupAci_i  (bus.req_aci),
    .lookupEksi_i (bus.req_eksi),
    .hit_o        (cacheHit)
  );
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lutAci_d  = lutAci_q;
    lutEksi_d = lutEksi_q;
    lutMode_d = lutMode_q;
    cosCoef_d = cosCoef_q;
    sinCoef_d = sinCoef_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          lutAci_d  = bus.req_aci;
          lutEksi_d = bus.req_eksi;
          lutMode_d = 1'b0;
          cnt_d     = '0;
          state_d   = COS;
`ifdef ROT_COEF_CACHE_EN
          if (cacheHit) state_d = DONE;
`endif
        end
      end
      COS: begin
        if (lastPhase) begin
          cosCoef_d = bus.lut_out;
          lutMode_d = 1'b1;
          cnt_d     = '0;
          state_d   = SIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SIN: begin
        if (lastPhase) begin
          sinCoef_d = bus.lut_out;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (bus.coef_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lutAci_q  <= '0;
      lutEksi_q <= 1'b0;
      lutMode_q <= 1'b0;
      cosCoef_q <= '0;
      sinCoef_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lutAci_q  <= lutAci_d;
      lutEksi_q <= lutEksi_d;
      lutMode_q <= lutMode_d;
      cosCoef_q <= cosCoef_d;
      sinCoef_q <= sinCoef_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.coef_valid = (state_q == DONE);
  assign bus.lut_aci    = lutAci_q;
  assign bus.lut_eksi   = lutEksi_q;
  assign bus.lut_mode   = lutMode_q;
  assign bus.cos_q      = cosCoef_q;
  assign bus.sin_q      = sinCoef_q;
  assign busy           = (state_q != IDLE);

endmodule
